// File: rtl/text_console_engine_if.sv
// text_console_engine_if: key-event handshake and character RAM write port of the text console engine.
interface text_console_engine_if #(
    parameter int COL_W = 7,
    parameter int ROW_W = 6
);
    logic                   key_valid;
    logic                   key_ready;
    logic [2:0]             key_kind;
    logic [6:0]             key_char;
    logic                   ram_we;
    logic [ROW_W+COL_W-1:0] ram_addr;
    logic [6:0]             ram_din;
    modport master (
        output key_valid, key_kind, key_char,
        input  key_ready, ram_we, ram_addr, ram_din
    );
    modport slave (
        input  key_valid, key_kind, key_char,
        output key_ready, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/text_console_engine.sv
// text_console_engine: keyboard-driven text console with cursor, hardware scroll, line/screen clear and cursor blink.
module text_console_engine #(
    parameter int         COLS         = 128,
    parameter int         ROWS         = 48,
    parameter int         COL_W        = 7,
    parameter int         ROW_W        = 6,
    parameter logic [6:0] BLANK        = 7'h20,
    parameter bit         WRAP_MODE    = 1'b0,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    text_console_engine_if.slave bus,
    input  logic                 frame_tick,
    output logic [COL_W-1:0]     cur_col,
    output logic [ROW_W-1:0]     cur_row,
    output logic [ROW_W-1:0]     top_row,
    output logic                 cursor_on
);
    localparam int               BW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [COL_W:0]   NCOLS      = (COL_W+1)'(COLS);
    localparam logic [ROW_W:0]   NROWS      = (ROW_W+1)'(ROWS);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, CLR_LINE, CLR_ALL} state_t;
    typedef enum logic [2:0] {K_CHAR, K_LEFT, K_RIGHT, K_UP, K_DOWN, K_ENTER, K_BKSP, K_CLEAR} kind_t;

    state_t                 state, state_n;
    kind_t                  kind_q, kind_n;
    logic [6:0]             char_q, char_n, din_q, din_n;
    logic [COL_W-1:0]       col_n;
    logic [ROW_W-1:0]       row_n, top_n;
    logic [COL_W:0]         clr_col, clr_col_n;
    logic [ROW_W:0]         clr_row, clr_row_n;
    logic [BW-1:0]          blink_cnt, blink_n;
    logic [ROW_W+COL_W-1:0] addr_q, addr_n;
    logic                   we_q, we_n, on_n, newline, accept;

    function automatic logic [ROW_W-1:0] phys(input logic [ROW_W-1:0] top, input logic [ROW_W-1:0] row);
        logic [ROW_W:0] s;
        s = {1'b0, top} + {1'b0, row};
        return (s >= NROWS) ? ROW_W'(s - NROWS) : ROW_W'(s);
    endfunction

    assign accept        = (state == IDLE) && bus.key_valid;
    assign bus.key_ready = (state == IDLE);
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_din   = din_q;

    // Two-cycle ops (CHAR, BKSP) use we_q as their phase: first cycle issues the write, second finishes.
    always_comb begin
        state_n   = state;
        kind_n    = kind_q;
        char_n    = char_q;
        col_n     = cur_col;
        row_n     = cur_row;
        top_n     = top_row;
        clr_col_n = clr_col;
        clr_row_n = clr_row;
        we_n      = 1'b0;
        addr_n    = addr_q;
        din_n     = BLANK;
        newline   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                kind_n    = kind_t'(bus.key_kind);
                char_n    = bus.key_char;
                clr_col_n = '0;
                clr_row_n = '0;
                state_n   = (kind_t'(bus.key_kind) == K_CLEAR) ? CLR_ALL : WRITE;
            end
            WRITE: begin
                state_n = IDLE;
                case (kind_q)
                    K_CHAR: if (!we_q) begin
                        state_n = WRITE;
                        we_n    = 1'b1;
                        din_n   = char_q;
                        addr_n  = {phys(top_row, cur_row), cur_col};
                    end else begin
                        newline = (cur_col == LAST_COL);
                        col_n   = newline ? '0 : cur_col + 1'b1;
                    end
                    K_LEFT:  col_n = (cur_col == '0) ? cur_col : cur_col - 1'b1;
                    K_RIGHT: col_n = (cur_col == LAST_COL) ? cur_col : cur_col + 1'b1;
                    K_UP:    row_n = (cur_row == '0) ? cur_row : cur_row - 1'b1;
                    K_DOWN:  row_n = (cur_row == LAST_ROW) ? cur_row : cur_row + 1'b1;
                    K_ENTER: begin
                        col_n   = '0;
                        newline = 1'b1;
                    end
                    K_BKSP: if (!we_q) begin
                        state_n = WRITE;
                        we_n    = 1'b1;
                        col_n   = (cur_col != '0) ? cur_col - 1'b1 : (cur_row != '0) ? LAST_COL : '0;
                        row_n   = (cur_col == '0 && cur_row != '0) ? cur_row - 1'b1 : cur_row;
                        addr_n  = {phys(top_row, row_n), col_n};
                    end
                    default: ;
                endcase
                if (newline) begin
                    if (cur_row != LAST_ROW) row_n = cur_row + 1'b1;
                    else if (WRAP_MODE) row_n = '0;
                    else begin
                        top_n     = (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
                        clr_col_n = '0;
                        state_n   = CLR_LINE;
                    end
                end
            end
            // top_row already points past the old top, so screen row ROWS-1 is the recycled line.
            CLR_LINE: if (clr_col == NCOLS) state_n = IDLE;
            else begin
                we_n      = 1'b1;
                addr_n    = {phys(top_row, LAST_ROW), clr_col[COL_W-1:0]};
                clr_col_n = clr_col + 1'b1;
            end
            CLR_ALL: if (clr_row == NROWS) begin
                state_n = IDLE;
                col_n   = '0;
                row_n   = '0;
                top_n   = '0;
            end else begin
                we_n      = 1'b1;
                addr_n    = {clr_row[ROW_W-1:0], clr_col[COL_W-1:0]};
                clr_col_n = (clr_col == NCOLS - 1'b1) ? '0 : clr_col + 1'b1;
                clr_row_n = (clr_col == NCOLS - 1'b1) ? clr_row + 1'b1 : clr_row;
            end
            default: state_n = IDLE;
        endcase
        on_n    = cursor_on;
        blink_n = blink_cnt;
        if (accept) begin
            on_n    = 1'b1;
            blink_n = '0;
        end else if (frame_tick) begin
            on_n    = (blink_cnt == BLINK_LAST) ? ~cursor_on : cursor_on;
            blink_n = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            kind_q    <= K_CHAR;
            char_q    <= '0;
            cur_col   <= '0;
            cur_row   <= '0;
            top_row   <= '0;
            clr_col   <= '0;
            clr_row   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            cursor_on <= 1'b1;
            blink_cnt <= '0;
        end else begin
            state     <= state_n;
            kind_q    <= kind_n;
            char_q    <= char_n;
            cur_col   <= col_n;
            cur_row   <= row_n;
            top_row   <= top_n;
            clr_col   <= clr_col_n;
            clr_row   <= clr_row_n;
            we_q      <= we_n;
            cursor_on <= on_n;
            blink_cnt <= blink_n;
            if (we_n) begin
                addr_q <= addr_n;
                din_q  <= din_n;
            end
        end
    end
endmodule

// File: tb/tb_text_console_engine.sv
// tb_text_console_engine: directed key sequences checked every cycle against a behavioural console model.
`timescale 1ns/1ps
module tb_text_console_engine;
    localparam int         COLS  = 128;
    localparam int         ROWS  = 48;
    localparam int         BF    = 2;
    localparam logic [6:0] BLANK = 7'h20;

    logic       clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
    logic [6:0] cur_col;
    logic [5:0] cur_row, top_row;
    logic       cursor_on;

    text_console_engine_if #(.COL_W(7), .ROW_W(6)) bus ();

    text_console_engine #(.COLS(COLS), .ROWS(ROWS), .COL_W(7), .ROW_W(6), .BLANK(BLANK),
                          .WRAP_MODE(1'b0), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .bus(bus), .frame_tick(frame_tick),
        .cur_col(cur_col), .cur_row(cur_row), .top_row(top_row), .cursor_on(cursor_on)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_fail = 0;
    int          m_col, m_row, m_top, m_busy, m_cnt;
    bit          m_on;
    int          wcount = 0, low_run = 0, last_low = 0, last_addr = -1, last_din = -1, w0;
    logic [19:0] wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input int prow, input int col, input int din);
        wq.push_back({13'(prow * COLS + col), 7'(din)});
    endfunction

    function automatic int phys(input int row);
        return (m_top + row) % ROWS;
    endfunction

    function automatic void model_reset();
        wq.delete();
        m_col = 0; m_row = 0; m_top = 0; m_busy = 0; m_cnt = 0; m_on = 1'b1;
    endfunction

    // Screen-level effect of one accepted key, plus how many cycles key_ready stays low.
    function automatic void model_event(input int k, input int c);
        int lat;
        bit nl;
        lat = 1;
        nl  = 1'b0;
        case (k)
            0: begin
                push(phys(m_row), m_col, c);
                lat = 2;
                if (m_col == COLS - 1) begin m_col = 0; nl = 1'b1; end
                else m_col++;
            end
            1: if (m_col > 0) m_col--;
            2: if (m_col < COLS - 1) m_col++;
            3: if (m_row > 0) m_row--;
            4: if (m_row < ROWS - 1) m_row++;
            5: begin m_col = 0; nl = 1'b1; end
            6: begin
                if (m_col > 0) m_col--;
                else if (m_row > 0) begin m_col = COLS - 1; m_row--; end
                push(phys(m_row), m_col, BLANK);
                lat = 2;
            end
            default: begin
                for (int r = 0; r < ROWS; r++)
                    for (int cc = 0; cc < COLS; cc++) push(r, cc, BLANK);
                m_col = 0; m_row = 0; m_top = 0;
                lat = ROWS * COLS + 1;
            end
        endcase
        if (nl) begin
            if (m_row < ROWS - 1) m_row++;
            else begin
                m_top = (m_top + 1) % ROWS;
                for (int cc = 0; cc < COLS; cc++) push(phys(ROWS - 1), cc, BLANK);
                lat += COLS + 1;
            end
        end
        m_busy = lat;
    endfunction

    always @(posedge clk) begin : mdl
        bit acc;
        if (!reset) begin
            acc = bus.key_valid && (m_busy == 0);
            if (m_busy > 0) m_busy--;
            if (acc) model_event(int'(bus.key_kind), int'(bus.key_char));
            if (acc) begin
                m_on  = 1'b1;
                m_cnt = 0;
            end else if (frame_tick) begin
                m_cnt++;
                if (m_cnt == BF) begin m_on = !m_on; m_cnt = 0; end
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [19:0] e;
        if (reset) begin
            chk("rst_key_ready", bus.key_ready, 1);
            chk("rst_ram_we", bus.ram_we, 0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_ram_din", bus.ram_din, 0);
            chk("rst_cur_col", cur_col, 0);
            chk("rst_cur_row", cur_row, 0);
            chk("rst_top_row", top_row, 0);
            chk("rst_cursor_on", cursor_on, 1);
        end else begin
            chk("key_ready", bus.key_ready, m_busy == 0);
            chk("cursor_on", cursor_on, m_on);
            if (m_busy == 0) begin
                chk("cur_col", cur_col, m_col);
                chk("cur_row", cur_row, m_row);
                chk("top_row", top_row, m_top);
                chk("pending_writes", wq.size(), 0);
            end
            if (bus.ram_we) begin
                wcount++;
                last_addr = int'(bus.ram_addr);
                last_din  = int'(bus.ram_din);
                if (wq.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h din 0x%0h, required no write at %0t", bus.ram_addr, bus.ram_din, $time);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", bus.ram_addr, e[19:7]);
                    chk("wr_din", bus.ram_din, e[6:0]);
                end
            end
            if (!bus.key_ready) low_run++;
            else begin
                if (low_run > 0) last_low = low_run;
                low_run = 0;
            end
        end
    end

    task automatic send(input int k, input int c, input bit tk = 1'b0);
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_busy != 0 && guard < 20000) begin @(negedge clk); guard++; end
        bus.key_valid = 1'b1;
        bus.key_kind  = 3'(k);
        bus.key_char  = 7'(c);
        frame_tick    = tk;
        @(posedge clk);
        #1 bus.key_valid = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic settle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (m_busy != 0 && guard < 20000) begin @(negedge clk); guard++; end
        @(negedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        bus.key_valid = 1'b0;
        bus.key_kind  = '0;
        bus.key_char  = '0;
        model_reset();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        send(0, 'h41); settle();
        chk("A_addr", last_addr, 0);
        chk("A_din", last_din, 'h41);
        chk("A_col", cur_col, 1);
        chk("A_ready", bus.key_ready, 1);
        chk("A_writes", wcount, 1);
        for (int i = 1; i < COLS; i++) send(0, 'h61 + i % 26);
        settle();
        chk("row0_last_addr", last_addr, 127);
        chk("row0_wrap_col", cur_col, 0);
        chk("row0_wrap_row", cur_row, 1);
        send(0, 'h42); settle();
        chk("row1_first_addr", last_addr, 128);
        tick(); tick();
        chk("blink_off", cursor_on, 0);
        tick();
        send(1, 0); settle();
        tick();
        chk("blink_restart_on", cursor_on, 1);
        tick();
        chk("blink_restart_off", cursor_on, 0);
        send(2, 0, 1'b1); settle();
        tick();
        chk("blink_tick_vs_key", cursor_on, 1);
        tick();
        chk("blink_after_key", cursor_on, 0);
        send(1, 0); send(1, 0); send(3, 0); send(3, 0); settle();
        chk("sat_col", cur_col, 0);
        chk("sat_row", cur_row, 0);
        send(5, 0); send(6, 0); settle();
        chk("bksp_up_addr", last_addr, 127);
        chk("bksp_up_din", last_din, 'h20);
        chk("bksp_up_col", cur_col, 127);
        send(6, 0);
        for (int i = 0; i < 50; i++) send(4, 0);
        for (int i = 0; i < 5; i++) send(2, 0);
        settle();
        chk("corner_col", cur_col, 127);
        chk("corner_row", cur_row, 47);
        w0 = wcount;
        send(0, 'h5A); settle();
        chk("scroll_top", top_row, 1);
        chk("scroll_writes", wcount - w0, 129);
        chk("scroll_last_addr", last_addr, 127);
        chk("scroll_busy_129", last_low >= 129, 1);
        w0 = wcount;
        send(5, 0); settle();
        chk("enter_scroll_top", top_row, 2);
        chk("enter_scroll_writes", wcount - w0, 128);
        chk("enter_scroll_last", last_addr, 255);
        send(6, 0); settle();
        chk("bksp_scrolled_addr", last_addr, 127);
        chk("bksp_scrolled_row", cur_row, 46);
        w0 = wcount;
        send(7, 0); settle();
        chk("clear_writes", wcount - w0, 6144);
        chk("clear_last_addr", last_addr, 6143);
        chk("clear_top", top_row, 0);
        send(6, 0); settle();
        chk("bksp_origin_addr", last_addr, 0);
        chk("bksp_origin_col", cur_col, 0);
        for (int i = 0; i < 5; i++) send(4, 0);
        send(6, 0); settle();
        chk("bksp_row5_addr", last_addr, 639);
        chk("bksp_row5_col", cur_col, 127);
        chk("bksp_row5_row", cur_row, 4);
        send(0, 'h33); settle();
        chk("char_eol_addr", last_addr, 639);
        chk("char_eol_row", cur_row, 5);
        send(7, 0);
        repeat (100) @(posedge clk);
        w0 = wcount;
        #3 reset = 1'b1;
        model_reset();
        #1 chk("abort_we", bus.ram_we, 0);
        chk("abort_ready", bus.key_ready, 1);
        chk("abort_cursor_on", cursor_on, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_resume", wcount - w0, 0);
        send(0, 'h43); settle();
        chk("post_abort_addr", last_addr, 0);
        chk("post_abort_col", cur_col, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
